// File: rtl/CPU_buffer_bus.sv
// Shared types for the pipeline inter-stage buffers and their central controller.
package CPU_buffer_bus;

   localparam int REG_ADDR_W = 5;
   localparam int PERF_CNT_W = 32;

   typedef enum logic {
      RUN        = 1'b0,
      FETCH_KILL = 1'b1
   } pctrl_state_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } buf_ctrl_t;

endpackage : CPU_buffer_bus

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
   import CPU_buffer_bus::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  load_use
);

   logic rd_nonzero;
   logic hit_rs1;
   logic hit_rs2;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign rd_nonzero = (ex_rd != '0);
   assign hit_rs1    = id_use_rs1 && (ex_rd == id_rs1);
   assign hit_rs2    = id_use_rs2 && (ex_rd == id_rs2);
   assign load_use   = ex_mem_read && rd_nonzero && (hit_rs1 || hit_rs2);

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with wrong-path fetch
// discard FSM and lost-cycle performance counters.
module pipeline_ctrl
   import CPU_buffer_bus::*;
(
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        if_pending,
   input  logic        if_rvalid,
   input  logic        dmem_busy,
   output logic        pc_stall,
   output logic        redirect_take,
   output logic        if_drop,
   output logic        stall_if2id,
   output logic        flush_if2id,
   output logic        stall_id2ex,
   output logic        flush_id2ex,
   output logic        stall_ex2mem,
   output logic        flush_ex2mem,
   output logic        stall_mem2wb,
   output logic [31:0] stall_cycles,
   output logic [31:0] bubble_count
);

   pctrl_state_t state_q, state_d, state_eff;
   logic [PERF_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [PERF_CNT_W-1:0] bubble_count_q, bubble_count_d;

   logic      load_use;
   logic      fetch_starved;
   buf_ctrl_t if2id_c, id2ex_c, ex2mem_c;
   logic      mem2wb_stall;
   logic      pc_hold;
   logic      take_redirect;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   // While reset is held the outputs behave as in RUN, even if the register still says FETCH_KILL.
   assign state_eff     = ARESET ? RUN : state_q;
   assign fetch_starved = if_pending && !if_rvalid;

   // State register and counters.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q        <= RUN;
         stall_cycles_q <= '0;
         bubble_count_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   // Next-state logic. Only an accepted redirect (not masked by dmem_busy) can leave
   // a wrong-path fetch in flight; the response cycle itself ends the kill window.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (!dmem_busy && ex_redirect && fetch_starved) state_d = FETCH_KILL;
         end
         FETCH_KILL: begin
            if (if_rvalid) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Output priority: memory wait > redirect > load-use > fetch starvation / kill.
   // NOTE: every output gets a default first so no path through the if-chain infers a latch.
   always_comb begin
      pc_hold       = 1'b0;
      take_redirect = 1'b0;
      if2id_c       = '0;
      id2ex_c       = '0;
      ex2mem_c      = '0;
      mem2wb_stall  = 1'b0;

      if (dmem_busy) begin
         pc_hold        = 1'b1;
         if2id_c.stall  = 1'b1;
         id2ex_c.stall  = 1'b1;
         ex2mem_c.stall = 1'b1;
         mem2wb_stall   = 1'b1;
      end else if (ex_redirect) begin
         take_redirect  = 1'b1;
         if2id_c.flush  = 1'b1;
         id2ex_c.flush  = 1'b1;
      end else if (load_use) begin
         pc_hold        = 1'b1;
         if2id_c.stall  = 1'b1;
         id2ex_c.flush  = 1'b1;
      end else if (state_eff == FETCH_KILL || fetch_starved) begin
         pc_hold        = 1'b1;
         if2id_c.flush  = 1'b1;
      end
   end

   // Each counter adds one for every cycle its event is asserted, wrapping naturally.
   always_comb begin
      stall_cycles_d = stall_cycles_q + {{(PERF_CNT_W-1){1'b0}}, pc_hold};
      bubble_count_d = bubble_count_q + {{(PERF_CNT_W-1){1'b0}}, id2ex_c.flush};
   end

   assign pc_stall      = pc_hold;
   assign redirect_take = take_redirect;
   assign if_drop       = (state_eff == FETCH_KILL);
   assign stall_if2id   = if2id_c.stall;
   assign flush_if2id   = if2id_c.flush;
   assign stall_id2ex   = id2ex_c.stall;
   assign flush_id2ex   = id2ex_c.flush;
   assign stall_ex2mem  = ex2mem_c.stall;
   assign flush_ex2mem  = ex2mem_c.flush;
   assign stall_mem2wb  = mem2wb_stall;
   assign stall_cycles  = stall_cycles_q;
   assign bubble_count  = bubble_count_q;

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl plus multi-cycle corner sequences.
module tb_pipeline_ctrl;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
   logic        if_pending, if_rvalid, dmem_busy;
   logic        pc_stall, redirect_take, if_drop;
   logic        stall_if2id, flush_if2id, stall_id2ex, flush_id2ex;
   logic        stall_ex2mem, flush_ex2mem, stall_mem2wb;
   logic [31:0] stall_cycles, bubble_count;

   int tests  = 0;
   int failed = 0;

   always #5 ACLK = ~ACLK;

   pipeline_ctrl dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_redirect   (ex_redirect),
      .if_pending    (if_pending),
      .if_rvalid     (if_rvalid),
      .dmem_busy     (dmem_busy),
      .pc_stall      (pc_stall),
      .redirect_take (redirect_take),
      .if_drop       (if_drop),
      .stall_if2id   (stall_if2id),
      .flush_if2id   (flush_if2id),
      .stall_id2ex   (stall_id2ex),
      .flush_id2ex   (flush_id2ex),
      .stall_ex2mem  (stall_ex2mem),
      .flush_ex2mem  (flush_ex2mem),
      .stall_mem2wb  (stall_mem2wb),
      .stall_cycles  (stall_cycles),
      .bubble_count  (bubble_count)
   );

   // Output vector order: pc_stall redirect_take if_drop stall_if2id flush_if2id
   //                      stall_id2ex flush_id2ex stall_ex2mem flush_ex2mem stall_mem2wb
   localparam logic [9:0] O_NONE  = 10'b0000000000;
   localparam logic [9:0] O_LU    = 10'b1001001000;
   localparam logic [9:0] O_REDIR = 10'b0100101000;
   localparam logic [9:0] O_BUSY  = 10'b1001010101;
   localparam logic [9:0] O_STARV = 10'b1000100000;
   localparam logic [9:0] O_KILL  = 10'b1010100000;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd;
      logic       mem_read;
      logic       redirect;
      logic       pending;
      logic       rvalid;
      logic       busy;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [9:0] outs();
      return {pc_stall, redirect_take, if_drop, stall_if2id, flush_if2id,
              stall_id2ex, flush_id2ex, stall_ex2mem, flush_ex2mem, stall_mem2wb};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input vec_t v);
      id_rs1      = v.rs1;
      id_rs2      = v.rs2;
      id_use_rs1  = v.use1;
      id_use_rs2  = v.use2;
      ex_rd       = v.rd;
      ex_mem_read = v.mem_read;
      ex_redirect = v.redirect;
      if_pending  = v.pending;
      if_rvalid   = v.rvalid;
      dmem_busy   = v.busy;
   endtask

   task automatic idle();
      vec_t z;
      z = '0;
      set_in(z);
   endtask

   task automatic cyc();
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   task automatic do_reset();
      idle();
      ARESET = 1'b1;
      cyc();
      cyc();
      ARESET = 1'b0;
   endtask

   initial begin
      //              rs1    rs2   u1 u2 rd    mr rd pe rv bz exp
      vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, O_NONE};
      vecs[1]  = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0, O_LU};
      vecs[2]  = '{5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, 0, O_NONE};
      vecs[3]  = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 0, O_LU};
      vecs[4]  = '{5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, 0, O_NONE};
      vecs[5]  = '{5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, 0, O_NONE};
      vecs[6]  = '{5'd3, 5'd9, 1, 1, 5'd4, 1, 0, 0, 0, 0, O_NONE};
      vecs[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, O_REDIR};
      vecs[8]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, O_REDIR};
      vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 0, O_REDIR};
      vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, O_BUSY};
      vecs[11] = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 1, O_BUSY};
      vecs[12] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, O_STARV};
      vecs[13] = '{5'd0, 5'd2, 0, 1, 5'd2, 1, 0, 1, 0, 0, O_LU};

      ARESET = 1'b1;
      idle();
      @(negedge ACLK);
      do_reset();

      check("reset_outs", 32'(outs()), 32'(O_NONE));
      check("reset_stall_cycles", stall_cycles, 32'd0);
      check("reset_bubble_count", bubble_count, 32'd0);

      // Combinational priority table, all in RUN.
      for (int i = 0; i < 14; i++) begin
         set_in(vecs[i]);
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
         cyc();
      end

      // Load-use costs exactly one bubble.
      do_reset();
      set_in(vecs[1]);
      #1;
      check("lu_outs", 32'(outs()), 32'(O_LU));
      check("lu_bubble_before", bubble_count, 32'd0);
      cyc();
      idle();
      #1;
      check("lu_after_outs", 32'(outs()), 32'(O_NONE));
      check("lu_bubble_after", bubble_count, 32'd1);
      check("lu_stall_after", stall_cycles, 32'd1);

      // Redirect with a fetch outstanding: 3 kill cycles + response cycle.
      do_reset();
      idle();
      ex_redirect = 1'b1;
      if_pending  = 1'b1;
      #1;
      check("fk_redirect_outs", 32'(outs()), 32'(O_REDIR));
      cyc();
      ex_redirect = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if_rvalid = (c == 4);
         #1;
         check($sformatf("fk_cycle%0d", c), 32'(outs()), 32'(O_KILL));
         cyc();
      end
      idle();
      #1;
      check("fk_exit_outs", 32'(outs()), 32'(O_NONE));
      check("fk_stall_cycles", stall_cycles, 32'd4);
      check("fk_bubble_count", bubble_count, 32'd1);

      // Data-memory wait masks a held redirect.
      do_reset();
      idle();
      ex_redirect = 1'b1;
      dmem_busy   = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check($sformatf("busy_cycle%0d", c), 32'(outs()), 32'(O_BUSY));
         cyc();
      end
      dmem_busy = 1'b0;
      #1;
      check("busy_release_redirect", 32'(outs()), 32'(O_REDIR));
      cyc();
      idle();
      #1;
      check("busy_stall_cycles", stall_cycles, 32'd5);
      check("busy_bubble_count", bubble_count, 32'd1);

      // Reset asserted in the second FETCH_KILL cycle.
      do_reset();
      idle();
      ex_redirect = 1'b1;
      if_pending  = 1'b1;
      cyc();
      ex_redirect = 1'b0;
      #1;
      check("rst_fk_first", 32'(if_drop), 32'd1);
      cyc();
      ARESET = 1'b1;
      #1;
      check("rst_fk_during_reset", 32'(outs()), 32'(O_STARV));
      cyc();
      ARESET = 1'b0;
      idle();
      #1;
      check("rst_fk_if_drop", 32'(if_drop), 32'd0);
      check("rst_fk_stall_cycles", stall_cycles, 32'd0);
      check("rst_fk_bubble_count", bubble_count, 32'd0);

      // Counter wrap after one starvation cycle.
      do_reset();
      force dut.stall_cycles_q = 32'hFFFF_FFFF;
      idle();
      if_pending = 1'b1;
      #1;
      release dut.stall_cycles_q;
      #1;
      check("wrap_preload", stall_cycles, 32'hFFFF_FFFF);
      cyc();
      idle();
      #1;
      check("wrap_stall_cycles", stall_cycles, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_pipeline_ctrl

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. It drives the `stall_en`/`flush_en` pins of every inter-stage buffer (IF2ID, ID2EX, EX2MEM, MEM2WB) plus the PC hold. It arbitrates load-use hazards, EX-stage redirects, fetch starvation and data-memory waits. A small FSM discards a wrong-path instruction fetch that is still outstanding when a redirect is taken. Two performance counters record lost cycles.

## Interface
Parameters:
- none

Ports:
- `ACLK` in 1: clock
- `ARESET` in 1: synchronous, active-high reset
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction reads rs1 / rs2
- `ex_rd` in 5: destination of the instruction in EX
- `ex_mem_read` in 1: the EX instruction is a load
- `ex_redirect` in 1: EX resolved a taken branch or jump (PC must change)
- `if_pending` in 1: an instruction fetch is outstanding, including its response cycle
- `if_rvalid` in 1: fetch response presented this cycle
- `dmem_busy` in 1: data-memory access in MEM not yet complete
- `pc_stall` out 1: hold PC, issue no new fetch
- `redirect_take` out 1: PC mux selects the EX target this cycle
- `if_drop` out 1: fetch unit discards any response this cycle
- `stall_if2id`, `flush_if2id`, `stall_id2ex`, `flush_id2ex`, `stall_ex2mem`, `flush_ex2mem`, `stall_mem2wb` out 1 each: buffer controls
- `stall_cycles` out 32: count of cycles with `pc_stall`=1
- `bubble_count` out 32: count of cycles with `flush_id2ex`=1

## Operation
- FSM has two states: RUN and FETCH_KILL.
- Definition: load_use = `ex_mem_read` & (`ex_rd`≠0) & ((`id_use_rs1` & `ex_rd`==`id_rs1`) | (`id_use_rs2` & `ex_rd`==`id_rs2`)).
- Outputs are combinational from state and inputs. The first matching rule applies; unlisted outputs are 0.
  1. `dmem_busy`: assert `pc_stall` and every `stall_*`. No flush. `redirect_take`=0, even if `ex_redirect` is high; EX is frozen, so the redirect is re-presented.
  2. `ex_redirect`: assert `redirect_take`, `flush_if2id` and `flush_id2ex`.
  3. load_use: assert `pc_stall` and `stall_if2id`, and assert `flush_id2ex` to insert one bubble. `flush_if2id` must stay 0.
  4. State is FETCH_KILL, or (`if_pending` & !`if_rvalid`): assert `pc_stall` and `flush_if2id`. This starves ID with a bubble.
- `if_drop`=1 whenever state is FETCH_KILL, regardless of the rule above.
- `flush_ex2mem` is always 0. The port is reserved for future exception support.
- RUN → FETCH_KILL: rule 2 applies and `if_pending`=1 and `if_rvalid`=0.
  - If `if_rvalid`=1 in the redirect cycle, the response is already removed by `flush_if2id`, so the FSM stays in RUN.
- FETCH_KILL → RUN: the cycle after `if_rvalid`=1 is sampled. This exit is independent of `dmem_busy`.
- A redirect accepted while in FETCH_KILL still performs its flushes, and the FSM stays in FETCH_KILL.
- Counters are 32-bit unsigned and wrap to 0 after 0xFFFF_FFFF.

## Timing
- Reset values: state RUN; both counters 0.
- Reset is sampled on `ACLK` and overrides everything, including mid-FETCH_KILL. Any later response is not dropped; the fetch unit is reset in the same cycle.
- While `ARESET`=1, combinational outputs still follow the rules above for state RUN.
- Buffers give flush priority over stall. This block never asserts both on the same buffer in one cycle.
- load_use costs exactly one bubble: the hazard is gone the next cycle because the load has moved to MEM.
- Redirect costs 2 bubbles, plus FETCH_KILL cycles if a fetch was outstanding.
- Counters update at the edge closing the counted cycle, so they are visible in the next cycle.

## Structure
- Add to the shared `CPU_buffer_bus` package:
  - `pctrl_state_t` enum {RUN, FETCH_KILL}
  - `buf_ctrl_t` struct {stall, flush}, for future bundling of buffer controls
- Sub-module `hazard_detect`: purely combinational load_use comparator. The FSM, priority logic and counters live in the top module.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for one cycle.
  - Required: `pc_stall`=`stall_if2id`=`flush_id2ex`=1, `flush_if2id`=0; `bubble_count` 0→1.
  - Repeat with `ex_rd`=0: all outputs 0.
- Redirect with no fetch outstanding:
  - Stimulus: `ex_redirect`=1, `if_pending`=0.
  - Required: `redirect_take`=`flush_if2id`=`flush_id2ex`=1; state stays RUN.
- Redirect with fetch outstanding:
  - Stimulus: `ex_redirect`=1, `if_pending`=1, `if_rvalid`=0; then `if_rvalid`=1 three cycles later.
  - Required: `if_drop`=1 and `pc_stall`=1 for exactly those 3 cycles plus the response cycle, then RUN; `stall_cycles`=4.
- Data-memory wait overrides redirect:
  - Stimulus: `dmem_busy`=1 for 5 cycles with `ex_redirect`=1 held.
  - Required: all stalls 1, `redirect_take`=0 for all 5 cycles; `redirect_take`=1 in cycle 6.
- Reset mid-FETCH_KILL:
  - Stimulus: assert `ARESET` in the second FETCH_KILL cycle.
  - Required: next cycle state RUN, `if_drop`=0, both counters 0.
- Counter wrap:
  - Stimulus: force `stall_cycles`=0xFFFF_FFFF, then one starvation cycle.
  - Required: `stall_cycles` reads 0.
